// File: rtl/i2s_transmitter.sv
// Stereo I2S master transmitter (Philips format).
// Generates sclk/ws from the system clock and serialises one left/right
// pair per 64-bit frame, MSB first, one bit after each ws edge.
// A single holding buffer decouples the valid/ready producer from the frame
// timing; if it is empty at frame load the previous pair is replayed.
module i2s_transmitter #(
    parameter int WIDTH     = 24,
    parameter int SCLK_HALF = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] left_in,
    input  logic signed [WIDTH-1:0] right_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    sclk_out,
    output logic                    ws_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    localparam int               CNT_W    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

    logic [CNT_W-1:0]        half_cnt;
    logic [5:0]              bit_idx;
    logic [5:0]              bit_idx_nxt;
    logic                    half_wrap;
    logic                    sclk_fall;
    logic                    frame_load;
    logic                    accept;
    logic                    buf_full;
    logic                    take_p1;
    logic signed [WIDTH-1:0] buf_left;
    logic signed [WIDTH-1:0] buf_right;
    logic signed [WIDTH-1:0] act_left;
    logic signed [WIDTH-1:0] act_right;

    // Serial bit for frame position idx: left slot at 1..WIDTH, right slot at
    // 33..32+WIDTH, zero padding everywhere else (no sign extension).
    function automatic logic slot_bit(input logic [5:0]       idx,
                                      input logic [WIDTH-1:0] l,
                                      input logic [WIDTH-1:0] r);
        int               pos;
        logic [WIDTH-1:0] shifted;
        pos      = int'(idx);
        shifted  = '0;
        slot_bit = 1'b0;
        if (pos >= 1 && pos <= WIDTH) begin
            shifted  = l >> (WIDTH - pos);
            slot_bit = shifted[0];
        end else if (pos >= 33 && pos <= 32 + WIDTH) begin
            shifted  = r >> (WIDTH - (pos - 32));
            slot_bit = shifted[0];
        end
    endfunction

    assign half_wrap   = (half_cnt == CNT_LAST);
    assign sclk_fall   = half_wrap && sclk_out;
    assign bit_idx_nxt = bit_idx + 6'd1;
    assign frame_load  = sclk_fall && (bit_idx_nxt == 6'd0);
    assign ready_out   = !buf_full;
    assign accept      = valid_in && !buf_full;

    // Divide the system clock into the I2S bit clock; first edge after reset is rising
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            half_cnt <= '0;
            sclk_out <= 1'b0;
        end else if (half_wrap) begin
            half_cnt <= '0;
            sclk_out <= !sclk_out;
        end else begin
            half_cnt <= half_cnt + CNT_W'(1);
        end
    end

    // On each sclk falling edge advance the frame position, drive ws/sdata and load a new pair at position 0
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bit_idx         <= 6'd63;
            ws_out          <= 1'b0;
            sdata_out       <= 1'b0;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
            act_left        <= '0;
            act_right       <= '0;
        end else begin
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
            if (sclk_fall) begin
                bit_idx   <= bit_idx_nxt;
                ws_out    <= bit_idx_nxt[5];
                sdata_out <= slot_bit(bit_idx_nxt, act_left, act_right);
                if (frame_load) begin
                    frame_start_out <= 1'b1;
                    if (buf_full) begin
                        act_left  <= buf_left;
                        act_right <= buf_right;
                    end else begin
                        underrun_out <= 1'b1;
                    end
                end
            end
        end
    end

    // Holding-buffer occupancy: set on accept, cleared the cycle after the frame load consumed it
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            buf_full <= 1'b0;
            take_p1  <= 1'b0;
        end else begin
            take_p1 <= frame_load && buf_full;
            if (take_p1) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
            end
        end
    end

    // Holding-buffer data: captured on accept, contents only meaningful while buf_full
    always_ff @(posedge clk_in) begin
        if (accept) begin
            buf_left  <= left_in;
            buf_right <= right_in;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: a small-divider instance for framing,
// handshake, underrun and reset behaviour, plus a default-parameter instance
// for frame/bit-clock timing.
module tb_i2s_transmitter;

    localparam int W  = 24;
    localparam int SH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n, valid, ready, sclk, ws, sdata, fs, ur;
    logic [W-1:0] left, right;
    logic         rst_d, valid_d, ready_d, sclk_d, ws_d, sdata_d, fs_d, ur_d;
    logic [W-1:0] left_d, right_d;

    i2s_transmitter #(.WIDTH(W), .SCLK_HALF(SH)) dut (
        .clk_in(clk), .rst_in(rst_n), .left_in(left), .right_in(right),
        .valid_in(valid), .ready_out(ready), .sclk_out(sclk), .ws_out(ws),
        .sdata_out(sdata), .frame_start_out(fs), .underrun_out(ur)
    );

    i2s_transmitter dut_d (
        .clk_in(clk), .rst_in(rst_d), .left_in(left_d), .right_in(right_d),
        .valid_in(valid_d), .ready_out(ready_d), .sclk_out(sclk_d), .ws_out(ws_d),
        .sdata_out(sdata_d), .frame_start_out(fs_d), .underrun_out(ur_d)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
        logic [2:0]   exp_rdy;   // ready at {fs+2, fs+1, fs} cycles
    } vec_t;
    vec_t vecs[6];

    logic [2*W-1:0] q[$];
    logic           feed_en = 1'b0;

    localparam logic [63:0] WS_PATTERN = 64'h00000000_FFFFFFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected 64-bit frame as seen on successive sclk rising edges, b0 first.
    function automatic logic [63:0] efr(input logic [W-1:0] l, input logic [W-1:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // Wait for frame_start, then record sdata/ws on the next 64 sclk rising edges.
    task automatic capture(output logic [63:0] frm, output logic [63:0] wsf, output logic u,
                           output logic [2:0] rdy, output int fs_cyc, output logic ok);
        int   n;
        int   k;
        logic prev;
        frm = '0; wsf = '0; u = 1'b0; rdy = '0; fs_cyc = 0; ok = 1'b0;
        n = 0;
        @(negedge clk);
        while (!fs && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!fs) return;
        fs_cyc = cyc;
        u      = ur;
        rdy[0] = ready;
        prev   = sclk;
        k = 0;
        n = 0;
        while (k < 64 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) rdy[1] = ready;
            if (n == 2) rdy[2] = ready;
            if (sclk && !prev) begin
                frm[63-k] = sdata;
                wsf[63-k] = ws;
                k++;
            end
            prev = sclk;
        end
        ok = (k == 64);
    endtask

    // Producer: presents the queue head and pops it once the handshake completes.
    initial begin
        logic acc;
        valid = 1'b0;
        left  = '0;
        right = '0;
        forever begin
            @(negedge clk);
            acc = feed_en && valid && ready && rst_n;
            @(posedge clk);
            #1;
            if (feed_en) begin
                if (acc) void'(q.pop_front());
                if (q.size() > 0) begin
                    valid = 1'b1;
                    {left, right} = q[0];
                end else begin
                    valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [63:0] frm, wsf;
        logic        u, ok, late_ok, late_rdy, found;
        logic [2:0]  rdy;
        int          fs_cyc, rel, n, ur_cnt;
        int          fs_t[$], rise_t[$], ws_t[$];
        logic        prev_s, prev_w;

        vecs[0] = '{l: 24'hA5C3F1, r: 24'h000001, exp_l: 24'hA5C3F1, exp_r: 24'h000001, exp_rdy: 3'b010};
        vecs[1] = '{l: 24'h800000, r: 24'h7FFFFF, exp_l: 24'h800000, exp_r: 24'h7FFFFF, exp_rdy: 3'b010};
        vecs[2] = '{l: 24'hFFFFFF, r: 24'h000000, exp_l: 24'hFFFFFF, exp_r: 24'h000000, exp_rdy: 3'b010};
        vecs[3] = '{l: 24'h000000, r: 24'hFFFFFF, exp_l: 24'h000000, exp_r: 24'hFFFFFF, exp_rdy: 3'b010};
        vecs[4] = '{l: 24'h5A5A5A, r: 24'hC3C3C3, exp_l: 24'h5A5A5A, exp_r: 24'hC3C3C3, exp_rdy: 3'b010};
        vecs[5] = '{l: 24'h123456, r: 24'h654321, exp_l: 24'h123456, exp_r: 24'h654321, exp_rdy: 3'b110};

        rst_n = 1'b0; rst_d = 1'b0;
        valid_d = 1'b0; left_d = '0; right_d = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({sclk, ws, sdata, fs, ur, ready}), 64'(6'b000001));

        // Continuous supply from the vector table, first pair accepted before the first load
        foreach (vecs[i]) q.push_back({vecs[i].l, vecs[i].r});
        feed_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        for (int i = 0; i < 6; i++) begin
            capture(frm, wsf, u, rdy, fs_cyc, ok);
            chk($sformatf("vec%0d_timeout", i), 64'(ok), 64'(1));
            if (i == 0) begin
                chk("first_load_latency", 64'(fs_cyc - rel), 64'(4));
                chk("vec0_literal_frame", frm, 64'h52E1F880_00000080);
            end
            chk($sformatf("vec%0d_frame", i), frm, efr(vecs[i].exp_l, vecs[i].exp_r));
            chk($sformatf("vec%0d_ws", i), wsf, WS_PATTERN);
            chk($sformatf("vec%0d_underrun", i), 64'(u), 64'(0));
            chk($sformatf("vec%0d_ready", i), 64'(rdy), 64'(vecs[i].exp_rdy));
        end
        feed_en = 1'b0;

        // Supply stopped: last pair repeats with an underrun pulse
        capture(frm, wsf, u, rdy, fs_cyc, ok);
        chk("underrun_timeout", 64'(ok), 64'(1));
        chk("underrun_flag", 64'(u), 64'(1));
        chk("underrun_repeat_frame", frm, efr(24'h123456, 24'h654321));
        chk("underrun_ready", 64'(rdy), 64'(3'b111));

        // Late arrival: valid_in in the exact frame_start cycle with the buffer empty
        late_ok = 1'b0;
        late_rdy = 1'b1;
        fork
            capture(frm, wsf, u, rdy, fs_cyc, ok);
            begin
                int m;
                m = 0;
                @(posedge clk);
                #1;
                while (!fs && m < 600) begin
                    @(posedge clk);
                    #1;
                    m++;
                end
                late_ok = fs;
                left = 24'h0F0F0F;
                right = 24'hF0F0F0;
                valid = 1'b1;
                @(posedge clk);
                #1;
                valid = 1'b0;
                late_rdy = ready;
            end
        join
        chk("late_timeout", 64'({ok, late_ok}), 64'(2'b11));
        chk("late_underrun", 64'(u), 64'(1));
        chk("late_old_pair_frame", frm, efr(24'h123456, 24'h654321));
        chk("late_ready_after_accept", 64'(late_rdy), 64'(0));
        chk("late_ready_seq", 64'(rdy), 64'(3'b001));

        capture(frm, wsf, u, rdy, fs_cyc, ok);
        chk("late_next_timeout", 64'(ok), 64'(1));
        chk("late_next_underrun", 64'(u), 64'(0));
        chk("late_next_frame", frm, efr(24'h0F0F0F, 24'hF0F0F0));
        chk("late_next_ws", wsf, WS_PATTERN);
        chk("late_next_ready", 64'(rdy), 64'(3'b110));

        // Asynchronous reset in the middle of the right slot
        n = 0;
        found = 1'b0;
        while (!found && n < 600) begin
            @(negedge clk);
            n++;
            found = ws && sdata;
        end
        chk("right_slot_reached", 64'(found), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({sclk, ws, sdata, fs, ur, ready}), 64'(6'b000001));
        left = 24'h777777;
        right = 24'h333333;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ignores_valid", 64'({ready, fs, ur}), 64'(3'b100));
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        capture(frm, wsf, u, rdy, fs_cyc, ok);
        chk("post_reset_timeout", 64'(ok), 64'(1));
        chk("post_reset_latency", 64'(fs_cyc - rel), 64'(4));
        chk("post_reset_underrun", 64'(u), 64'(1));
        chk("post_reset_zero_frame", frm, 64'h0);
        chk("post_reset_ws", wsf, WS_PATTERN);
        chk("post_reset_ready", 64'(rdy), 64'(3'b111));

        // Default parameters with continuous supply: frame, bit-clock and ws timing
        left_d = 24'h13579B;
        right_d = 24'h2468AC;
        valid_d = 1'b1;
        @(posedge clk);
        #1;
        rst_d = 1'b1;
        rel = cyc;
        ur_cnt = 0;
        prev_s = 1'b0;
        prev_w = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (fs_d) fs_t.push_back(cyc);
            if (ur_d) ur_cnt++;
            if (sclk_d && !prev_s) rise_t.push_back(cyc);
            if (ws_d != prev_w) ws_t.push_back(cyc);
            prev_s = sclk_d;
            prev_w = ws_d;
        end
        chk("t5_fs_count", 64'(fs_t.size()), 64'(3));
        chk("t5_first_fs", 64'((fs_t.size() > 0) ? fs_t[0] - rel : -1), 64'(32));
        chk("t5_fs_spacing1", 64'((fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1), 64'(2048));
        chk("t5_fs_spacing2", 64'((fs_t.size() > 2) ? fs_t[2] - fs_t[1] : -1), 64'(2048));
        chk("t5_first_rise", 64'((rise_t.size() > 0) ? rise_t[0] - rel : -1), 64'(16));
        chk("t5_sclk_period", 64'((rise_t.size() > 1) ? rise_t[1] - rise_t[0] : -1), 64'(32));
        chk("t5_first_ws_toggle", 64'((ws_t.size() > 0) ? ws_t[0] - rel : -1), 64'(1056));
        chk("t5_ws_spacing", 64'((ws_t.size() > 1) ? ws_t[1] - ws_t[0] : -1), 64'(1024));
        chk("t5_no_underrun", 64'(ur_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Stereo I2S master transmitter that drives an external audio DAC from processed or pitch-shifted audio.
- Output counterpart of the mic-side I2S receiver; generates its own sclk and ws from the system clock.
- Accepts left/right sample pairs over a valid/ready handshake into a one-entry holding buffer.
- Serialises each pair MSB-first in standard Philips I2S format: 64 sclk per frame, 32-bit slots, one-bit data delay after each ws edge.

Parameters:
- WIDTH, 24: sample width in bits; must be ≤ 31.
- SCLK_HALF, 16: clk_in cycles per sclk half-period. The default gives 3.125 MHz sclk and 48.83 kHz frames at 100 MHz.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- left_in  input  WIDTH  left sample, two's complement
- right_in  input  WIDTH  right sample, two's complement
- valid_in  input  1  sample pair on left_in/right_in is valid
- ready_out  output  1  holding buffer empty; pair accepted when valid_in && ready_out
- sclk_out  output  1  I2S bit clock
- ws_out  output  1  I2S word select; 0 = left, 1 = right
- sdata_out  output  1  I2S serial data
- frame_start_out  output  1  one-cycle pulse when a new pair is loaded for transmission
- underrun_out  output  1  one-cycle pulse, coincident with frame_start_out, when the buffer was empty at load

Behaviour:
- Reset while rst_in = 0, asynchronous, takes effect immediately, also mid-frame:
  - sclk_out, ws_out, sdata_out, frame_start_out, underrun_out = 0; ready_out = 1.
  - Half-period counter = 0, bit index b = 63, active left/right registers = 0, buffer empty.
  - valid_in is ignored while in reset.
- sclk generation:
  - Counter runs 0..SCLK_HALF-1; at wrap, sclk_out toggles.
  - The first edge after reset release is a rising edge, SCLK_HALF cycles later.
  - The first falling edge comes 2*SCLK_HALF cycles after release.
- Falling edge (cycle in which sclk_out goes 1→0):
  - b advances modulo 64.
  - ws_out and sdata_out update in that same cycle; all outputs are registered.
  - The DAC samples sdata_out on the following rising edge.
- Framing:
  - ws_out = 1 when b ≥ 32, else 0.
  - b = 1..WIDTH: sdata_out = active_left[WIDTH-b], MSB first.
  - b = 33..32+WIDTH: sdata_out = active_right[WIDTH-(b-32)].
  - All other b, including b = 0 and b = 32: sdata_out = 0.
- Frame load, on the falling edge where b becomes 0:
  - Buffer full: active regs ← buffer, buffer emptied, frame_start_out = 1.
  - Buffer empty: active regs keep their previous pair (last pair repeats; zeros after reset), frame_start_out = 1, underrun_out = 1.
- Handshake:
  - ready_out = !buffer_full, driven combinationally from the registered flag.
  - Accept writes the buffer; the flag sets next cycle.
  - No bypass. valid_in in the same cycle as a load from an empty buffer produces an underrun; the new pair is buffered and played in the next frame.
  - Load and accept cannot collide, because accept requires the buffer to be empty.
- Latency:
  - ready_out rises the cycle after frame_start_out.
  - MSB of a loaded pair appears on sdata_out 2*SCLK_HALF cycles after frame_start_out.
  - Frame period is 128*SCLK_HALF cycles (2048 at the default).
- Width rules:
  - Samples are transmitted as-is, with no sign extension into padding bits.
  - Padding bits are always 0.

Test Plan:
1. Reset: SCLK_HALF = 2, drive rst_in low mid-right-slot → within the same cycle all outputs 0 and ready_out = 1; after release, the first frame_start_out comes 4 cycles later with underrun_out = 1.
2. Single pair: L = 0xA5C3F1, R = 0x000001, accepted before the first load → on sclk rising edges, b1..24 read 0xA5C3F1 MSB-first and b25..32 read 0; b33..56 read 0x000001; ws low for b0..31, high for b32..63.
3. Backpressure: hold valid_in with a second pair right after the first accept → ready_out = 0 until the cycle after frame_start_out; the second pair is accepted then and transmitted in the following frame.
4. Underrun: stop supplying pairs after 0x123456/0x654321 → the next frame repeats 0x123456/0x654321, and underrun_out pulses with frame_start_out.
5. Timing: default parameters, continuous supply → frame_start_out spacing is exactly 2048 cycles, sclk period 32 cycles, ws toggles every 1024 cycles, and underrun_out never asserts.
6. Late arrival: valid_in asserts in the exact frame_start cycle with the buffer empty → underrun_out = 1 and the old pair repeats; the new pair is transmitted in the next frame with no underrun.
